// File: rtl/icache_rd_responder_pkg.sv
// Shared definitions for the icache refill read responder: FSM encoding,
// burst geometry and the debug view of the responder state.
package icache_rd_responder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_BEAT  = 2'd3;

    localparam int BURST_BEATS = 4;
    localparam int LINE_OFF_W  = 4;
    localparam int BEAT_W      = 2;

    typedef struct packed {
        logic [1:0]        state;
        logic [BEAT_W-1:0] beat;
    } resp_dbg_t;

endpackage

// File: rtl/icache_rd_responder_rd_lat_ctr.sv
// Load/decrement down-counter with a zero flag, used to model slow memory.
// Only compiled when ICACHE_RESP_LAT_EN is defined.
`ifdef ICACHE_RESP_LAT_EN
module rd_lat_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule
`endif

// File: rtl/icache_rd_responder.sv
// Memory-side responder for the icache refill port: one AR request returns a
// 4-beat burst read from synchronous memory. ICACHE_RESP_LAT_EN adds RD_LAT wait cycles.
module icache_rd_responder
    import icache_rd_responder_pkg::*;
#(
    parameter int MEM_AW = 14,
    parameter int RD_LAT = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_arvalid,
    input  logic [31:0]       i_araddr,
    output logic              i_arready,
    output logic              i_rvalid,
    input  logic              i_rready,
    output logic [31:0]       i_rdata,
    output logic              i_rlast,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output resp_dbg_t         dbg
);

    // Handshakes: a transfer happens in a cycle where valid and ready are both
    // high; valid never waits on ready and, once raised, holds with stable
    // payload until that transfer.

    localparam int LINE_W = MEM_AW - BEAT_W;

    logic [1:0]        state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] addr_beat;
    logic              advance;
    logic              last_beat;
    logic              unused_addr;

`ifdef ICACHE_RESP_LAT_EN
    localparam int              CNT_W    = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
    localparam logic [CNT_W-1:0] LAT_LOAD = (RD_LAT > 0) ? CNT_W'(RD_LAT - 1) : '0;

    logic lat_load;
    logic lat_dec;
    logic lat_zero;

    assign lat_load = (state_q == ST_IDLE) && i_arvalid;
    assign lat_dec  = (state_q == ST_WAIT) && !lat_zero;

    rd_lat_ctr #(
        .W(CNT_W)
    ) u_rd_lat_ctr (
        .clk      (clk),
        .rstn     (rstn),
        .load     (lat_load),
        .load_val (LAT_LOAD),
        .dec      (lat_dec),
        .zero     (lat_zero)
    );
`else
    logic unused_rd_lat;
    assign unused_rd_lat = (RD_LAT != 0);
`endif

    // Byte offset within the line and bits above the memory are don't-care.
    assign unused_addr = ^{i_araddr[31:MEM_AW+2], i_araddr[LINE_OFF_W-1:0]};

    assign last_beat = (beat_q == BEAT_W'(BURST_BEATS - 1));

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        beat_d  = beat_q;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_arvalid) begin
                    line_d = i_araddr[MEM_AW+1:LINE_OFF_W];
                    beat_d = '0;
`ifdef ICACHE_RESP_LAT_EN
                    state_d = (RD_LAT == 0) ? ST_ISSUE : ST_WAIT;
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
`ifdef ICACHE_RESP_LAT_EN
            ST_WAIT: begin
                if (lat_zero) begin
                    state_d = ST_ISSUE;
                end
            end
`endif
            ST_ISSUE: begin
                state_d = ST_BEAT;
            end
            ST_BEAT: begin
                if (i_rready) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
        end
    end

    // The next read is launched in the same cycle as the accepted beat so the
    // following beat lands one cycle later; a stall leaves the memory idle,
    // which keeps its output (and i_rdata) stable.
    assign addr_beat = advance ? (beat_q + BEAT_W'(1)) : beat_q;

    assign i_arready = (state_q == ST_IDLE);
    assign i_rvalid  = (state_q == ST_BEAT);
    assign i_rlast   = (state_q == ST_BEAT) && last_beat;
    assign i_rdata   = mem_rdata;
    assign mem_en    = (state_q == ST_ISSUE) || advance;
    assign mem_addr  = {line_q, addr_beat};

    always_comb begin
        dbg       = '0;
        dbg.state = state_q;
        dbg.beat  = beat_q;
    end

endmodule

// File: tb/tb_icache_rd_responder.sv
// Table-driven bench for icache_rd_responder with a synchronous memory model
// holding word i = 0x1000_0000 + i.
module tb_icache_rd_responder;
    import icache_rd_responder_pkg::*;

    localparam int MEM_AW = 14;
`ifdef ICACHE_RESP_LAT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 0;
`endif

    logic              clk;
    logic              rstn;
    logic              i_arvalid;
    logic [31:0]       i_araddr;
    logic              i_arready;
    logic              i_rvalid;
    logic              i_rready;
    logic [31:0]       i_rdata;
    logic              i_rlast;
    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    resp_dbg_t         dbg;

    int n_total;
    int n_pass;

    icache_rd_responder #(
        .MEM_AW(MEM_AW),
        .RD_LAT(3)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_arvalid (i_arvalid),
        .i_araddr  (i_araddr),
        .i_arready (i_arready),
        .i_rvalid  (i_rvalid),
        .i_rready  (i_rready),
        .i_rdata   (i_rdata),
        .i_rlast   (i_rlast),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .dbg       (dbg)
    );

    // clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= 32'h1000_0000 + 32'(mem_addr);
    end

    typedef struct {
        logic        av;
        logic [31:0] aa;
        logic        rr;
        logic        e_ar;
        logic        e_rv;
        logic        e_rl;
        logic        e_me;
        logic [13:0] e_ad;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic av, input logic [31:0] aa, input logic rr,
                       input logic e_ar, input logic e_rv, input logic e_rl, input logic e_me,
                       input logic [13:0] e_ad, input logic [31:0] e_rd);
        vec_t v;
        v.av = av; v.aa = aa; v.rr = rr;
        v.e_ar = e_ar; v.e_rv = e_rv; v.e_rl = e_rl; v.e_me = e_me;
        v.e_ad = e_ad; v.e_rd = e_rd;
        vecs.push_back(v);
    endtask

    // Slow-memory build: WAIT cycles with nothing visible but busy.
    task automatic add_wait(input logic av, input logic [31:0] aa);
        for (int w = 0; w < LAT; w++) add(av, aa, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0);
    endtask

    // Called at posedge+1; drives a row, checks at the falling edge.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            i_arvalid = vecs[i].av;
            i_araddr  = vecs[i].aa;
            i_rready  = vecs[i].rr;
            @(negedge clk);
            chk($sformatf("%s[%0d] arready", tag, i), 32'(i_arready), 32'(vecs[i].e_ar));
            chk($sformatf("%s[%0d] rvalid", tag, i), 32'(i_rvalid), 32'(vecs[i].e_rv));
            chk($sformatf("%s[%0d] rlast", tag, i), 32'(i_rlast), 32'(vecs[i].e_rl));
            chk($sformatf("%s[%0d] mem_en", tag, i), 32'(mem_en), 32'(vecs[i].e_me));
            if (vecs[i].e_me) chk($sformatf("%s[%0d] mem_addr", tag, i), 32'(mem_addr), 32'(vecs[i].e_ad));
            if (vecs[i].e_rv) chk($sformatf("%s[%0d] rdata", tag, i), i_rdata, vecs[i].e_rd);
            @(posedge clk);
            #1;
        end
        vecs.delete();
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rstn      = 1'b0;
        i_arvalid = 1'b0;
        i_araddr  = '0;
        i_rready  = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst arready", 32'(i_arready), 32'd1);
        chk("rst rvalid", 32'(i_rvalid), 32'd0);
        chk("rst rlast", 32'(i_rlast), 32'd0);
        chk("rst mem_en", 32'(mem_en), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst state", 32'(dbg.state), 32'(ST_IDLE));
        chk("rst beat", 32'(dbg.beat), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // aligned 0x40, full rready
        add(1, 32'h40, 1,  1, 0, 0, 0, 14'h000, 32'h0);
        add_wait(0, 32'h0);
        add(0, 32'h0, 1,   0, 0, 0, 1, 14'h010, 32'h0);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h011, 32'h1000_0010);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h012, 32'h1000_0011);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h013, 32'h1000_0012);
        add(0, 32'h0, 1,   0, 1, 1, 0, 14'h000, 32'h1000_0013);
        // unaligned 0x4C returns the same line
        add(1, 32'h4C, 1,  1, 0, 0, 0, 14'h000, 32'h0);
        add_wait(0, 32'h0);
        add(0, 32'h0, 1,   0, 0, 0, 1, 14'h010, 32'h0);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h011, 32'h1000_0010);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h012, 32'h1000_0011);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h013, 32'h1000_0012);
        add(0, 32'h0, 1,   0, 1, 1, 0, 14'h000, 32'h1000_0013);
        // 0x1230 with rready low for two cycles on beat 1
        add(1, 32'h1230, 1, 1, 0, 0, 0, 14'h000, 32'h0);
        add_wait(0, 32'h0);
        add(0, 32'h0, 1,   0, 0, 0, 1, 14'h48C, 32'h0);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h48D, 32'h1000_048C);
        add(0, 32'h0, 0,   0, 1, 0, 0, 14'h000, 32'h1000_048D);
        add(0, 32'h0, 0,   0, 1, 0, 0, 14'h000, 32'h1000_048D);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h48E, 32'h1000_048D);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h48F, 32'h1000_048E);
        add(0, 32'h0, 1,   0, 1, 1, 0, 14'h000, 32'h1000_048F);
        // bit 16 is above the memory and aliases onto line 0x004
        add(1, 32'h0001_0040, 1, 1, 0, 0, 0, 14'h000, 32'h0);
        add_wait(0, 32'h0);
        add(0, 32'h0, 1,   0, 0, 0, 1, 14'h010, 32'h0);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h011, 32'h1000_0010);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h012, 32'h1000_0011);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h013, 32'h1000_0012);
        add(0, 32'h0, 1,   0, 1, 1, 0, 14'h000, 32'h1000_0013);
        // topmost line of memory
        add(1, 32'h0000_FFF0, 1, 1, 0, 0, 0, 14'h000, 32'h0);
        add_wait(0, 32'h0);
        add(0, 32'h0, 1,   0, 0, 0, 1, 14'h3FFC, 32'h0);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h3FFD, 32'h1000_3FFC);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h3FFE, 32'h1000_3FFD);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h3FFF, 32'h1000_3FFE);
        add(0, 32'h0, 1,   0, 1, 1, 0, 14'h000, 32'h1000_3FFF);
        // back-to-back: arvalid held, second address latched only at accept
        add(1, 32'h80, 1,  1, 0, 0, 0, 14'h000, 32'h0);
        add_wait(1, 32'hC0);
        add(1, 32'hC0, 1,  0, 0, 0, 1, 14'h020, 32'h0);
        add(1, 32'hC0, 1,  0, 1, 0, 1, 14'h021, 32'h1000_0020);
        add(1, 32'hC0, 1,  0, 1, 0, 1, 14'h022, 32'h1000_0021);
        add(1, 32'hC0, 1,  0, 1, 0, 1, 14'h023, 32'h1000_0022);
        add(1, 32'hC0, 1,  0, 1, 1, 0, 14'h000, 32'h1000_0023);
        add(1, 32'hC0, 1,  1, 0, 0, 0, 14'h000, 32'h0);
        add_wait(0, 32'h0);
        add(0, 32'h0, 1,   0, 0, 0, 1, 14'h030, 32'h0);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h031, 32'h1000_0030);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h032, 32'h1000_0031);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h033, 32'h1000_0032);
        add(0, 32'h0, 1,   0, 1, 1, 0, 14'h000, 32'h1000_0033);
        add(0, 32'h0, 0,   1, 0, 0, 0, 14'h000, 32'h0);
        run_vecs("main");

        // mid-burst reset while beat 1 is presented
        add(1, 32'h100, 1, 1, 0, 0, 0, 14'h000, 32'h0);
        add_wait(0, 32'h0);
        add(0, 32'h0, 1,   0, 0, 0, 1, 14'h040, 32'h0);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h041, 32'h1000_0040);
        run_vecs("pre_rst");
        i_rready = 1'b1;
        @(negedge clk);
        chk("midrst busy rvalid", 32'(i_rvalid), 32'd1);
        rstn = 1'b0;
        #1;
        chk("midrst rvalid", 32'(i_rvalid), 32'd0);
        chk("midrst arready", 32'(i_arready), 32'd1);
        chk("midrst rlast", 32'(i_rlast), 32'd0);
        chk("midrst mem_en", 32'(mem_en), 32'd0);
        chk("midrst mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) add(0, 32'h0, 1, 1, 0, 0, 0, 14'h000, 32'h0);
        add(1, 32'h200, 1, 1, 0, 0, 0, 14'h000, 32'h0);
        add_wait(0, 32'h0);
        add(0, 32'h0, 1,   0, 0, 0, 1, 14'h080, 32'h0);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h081, 32'h1000_0080);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h082, 32'h1000_0081);
        add(0, 32'h0, 1,   0, 1, 0, 1, 14'h083, 32'h1000_0082);
        add(0, 32'h0, 1,   0, 1, 1, 0, 14'h000, 32'h1000_0083);
        add(0, 32'h0, 0,   1, 0, 0, 0, 14'h000, 32'h0);
        run_vecs("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
